// File: rtl/idu_is_aiq_sched_if.sv
// ALU issue queue scheduler bundle: dispatch handshake, entry status and
// per-entry create/issue strobes.
interface idu_is_aiq_sched_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);
  logic             dis_vld;
  logic             aiq_full;
  logic             aiq_empty;
  logic [CNT_W-1:0] aiq_entry_cnt;
  logic [DEPTH-1:0] aiq_create_vld;
  logic [IDX_W-1:0] aiq_create_idx;
  logic [DEPTH-1:0] entry_vld;
  logic [DEPTH-1:0] entry_ready;
  logic             alu_issue_ready;
  logic [DEPTH-1:0] aiq_issue_vld;
  logic             is_issue_vld;
  logic [IDX_W-1:0] is_issue_idx;

  // Dispatch / entry array / ALU pipe side
  modport master (
    output dis_vld, entry_vld, entry_ready, alu_issue_ready,
    input  aiq_full, aiq_empty, aiq_entry_cnt, aiq_create_vld, aiq_create_idx,
           aiq_issue_vld, is_issue_vld, is_issue_idx
  );

  // Scheduler side
  modport slave (
    input  dis_vld, entry_vld, entry_ready, alu_issue_ready,
    output aiq_full, aiq_empty, aiq_entry_cnt, aiq_create_vld, aiq_create_idx,
           aiq_issue_vld, is_issue_vld, is_issue_idx
  );
endinterface

// File: rtl/idu_is_aiq_sched.sv
// ALU issue queue allocation/selection controller: lowest-free-entry
// allocation, age-matrix oldest-ready selection, occupancy counter.
module idu_is_aiq_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_clk,
  input  logic                  rtu_global_flush,
  idu_is_aiq_sched_if.slave     aiq
);

  // age[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0] age [DEPTH];
  logic [CNT_W-1:0] cnt;

  logic             full;
  logic             free_found;
  logic [DEPTH-1:0] free_oh;
  logic [IDX_W-1:0] free_idx;
  logic             create_en;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] win;
  logic [DEPTH-1:0] older;
  logic [IDX_W-1:0] win_idx;
  logic             issue_en;
  logic [DEPTH-1:0] issue_oh;

  assign full = (cnt == CNT_W'(DEPTH));

  // Pick the lowest-index free entry for the incoming instruction
  always_comb begin
    free_found = 1'b0;
    free_oh    = '0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!aiq.entry_vld[i] && !free_found) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    create_en = aiq.dis_vld & ~full & ~rtu_global_flush & free_found;
  end

  // Oldest-ready selection: a candidate wins when no other candidate is older
  always_comb begin
    cand    = aiq.entry_ready & aiq.entry_vld;
    win     = '0;
    win_idx = '0;
    older   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      older = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i) older[j] = age[j][i];
      end
      win[i] = cand[i] & ~|(cand & older);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (win[i]) win_idx = win_idx | IDX_W'(i);
    end
    issue_en = aiq.alu_issue_ready & ~rtu_global_flush;
    issue_oh = win & {DEPTH{issue_en}};
  end

  // Age matrix: a newly created entry is younger than every currently valid one
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (rtu_global_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (create_en) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (free_oh[j]) age[j] <= '0;
        else            age[j][free_idx] <= aiq.entry_vld[j];
      end
    end
  end

  // Occupancy counter: create and issue in one cycle cancel out
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk)              cnt <= '0;
    else if (rtu_global_flush) cnt <= '0;
    else                       cnt <= cnt + CNT_W'(create_en) - CNT_W'(|issue_oh);
  end

  assign aiq.aiq_full       = full;
  assign aiq.aiq_empty      = (cnt == '0);
  assign aiq.aiq_entry_cnt  = cnt;
  assign aiq.aiq_create_vld = free_oh & {DEPTH{create_en}};
  assign aiq.aiq_create_idx = free_idx;
  assign aiq.aiq_issue_vld  = issue_oh;
  assign aiq.is_issue_vld   = |issue_oh;
  assign aiq.is_issue_idx   = win_idx;

  a_create_onehot: assert property (@(posedge clk) disable iff (!rst_clk)
    $onehot0(aiq.aiq_create_vld));
  a_issue_onehot: assert property (@(posedge clk) disable iff (!rst_clk)
    $onehot0(aiq.aiq_issue_vld));
  a_cnt_match: assert property (@(posedge clk) disable iff (!rst_clk)
    int'(cnt) == $countones(aiq.entry_vld));
  a_issue_ready: assert property (@(posedge clk) disable iff (!rst_clk)
    (aiq.aiq_issue_vld & ~aiq.entry_ready) == '0);
  a_create_free: assert property (@(posedge clk) disable iff (!rst_clk)
    (aiq.aiq_create_vld & aiq.entry_vld) == '0);

endmodule

// File: tb/tb_idu_is_aiq_sched.sv
// Bench for idu_is_aiq_sched. The reference keeps valid entries as a queue
// ordered oldest-first; the same queue also plays the entry array that
// drives entry_vld back into the scheduler.
module tb_idu_is_aiq_sched;
  localparam int unsigned D = 8;

  logic clk = 1'b0;
  logic rst_clk;
  logic flush;
  always #5 clk = ~clk;

  idu_is_aiq_sched_if #(.DEPTH(D)) aiq_if ();

  idu_is_aiq_sched #(.DEPTH(D)) dut (
    .clk              (clk),
    .rst_clk          (rst_clk),
    .rtu_global_flush (flush),
    .aiq              (aiq_if)
  );

  int q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [D-1:0] model_vld();
    logic [D-1:0] v = '0;
    foreach (q[k]) v[q[k]] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational/registered outputs, advance model at posedge
  task automatic step(input logic dis, input logic [D-1:0] rdy, input logic air, input logic fl);
    logic [D-1:0] vld, rdy_m, exp_c, exp_i;
    int ci, wi, pos;
    logic cv, iv;
    @(negedge clk);
    vld   = model_vld();
    rdy_m = rdy & vld;
    aiq_if.dis_vld         = dis;
    aiq_if.entry_vld       = vld;
    aiq_if.entry_ready     = rdy_m;
    aiq_if.alu_issue_ready = air;
    flush                  = fl;
    cv = dis && !fl && (q.size() < D);
    ci = -1;
    for (int i = 0; i < D; i++) if (!vld[i] && ci < 0) ci = i;
    exp_c = '0;
    if (cv) exp_c[ci] = 1'b1;
    wi = -1;
    foreach (q[k]) if (wi < 0 && rdy_m[q[k]]) wi = q[k];
    iv = air && !fl && (wi >= 0);
    exp_i = '0;
    if (iv) exp_i[wi] = 1'b1;
    #1;
    chk("cnt",        32'(aiq_if.aiq_entry_cnt),  32'(q.size()));
    chk("full",       32'(aiq_if.aiq_full),       32'(q.size() == D));
    chk("empty",      32'(aiq_if.aiq_empty),      32'(q.size() == 0));
    chk("create_vld", 32'(aiq_if.aiq_create_vld), 32'(exp_c));
    if (cv) chk("create_idx", 32'(aiq_if.aiq_create_idx), 32'(ci));
    chk("issue_vld",  32'(aiq_if.aiq_issue_vld),  32'(exp_i));
    chk("is_issue_vld", 32'(aiq_if.is_issue_vld), 32'(iv));
    if (iv) chk("is_issue_idx", 32'(aiq_if.is_issue_idx), 32'(wi));
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (iv) begin
        pos = -1;
        foreach (q[k]) if (q[k] == wi) pos = k;
        q.delete(pos);
      end
      if (cv) q.push_back(ci);
    end
  endtask

  task automatic idle_inputs();
    aiq_if.dis_vld         = 1'b0;
    aiq_if.entry_vld       = '0;
    aiq_if.entry_ready     = '0;
    aiq_if.alu_issue_ready = 1'b0;
    flush                  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cnt"},   32'(aiq_if.aiq_entry_cnt),  32'd0);
    chk({tag, "_empty"}, 32'(aiq_if.aiq_empty),      32'd1);
    chk({tag, "_full"},  32'(aiq_if.aiq_full),       32'd0);
    chk({tag, "_cvld"},  32'(aiq_if.aiq_create_vld), 32'd0);
    chk({tag, "_ivld"},  32'(aiq_if.aiq_issue_vld),  32'd0);
  endtask

  initial begin
    // Power-on reset
    rst_clk = 1'b0;
    idle_inputs();
    q.delete();
    @(negedge clk);
    #1 check_reset_state("por");
    @(negedge clk);
    rst_clk = 1'b1;

    // 1: fill all eight, ninth dispatch ignored while full
    repeat (9) step(1'b1, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // 2: entries 0..3, ready on 3 and 1 together -> 1 then 3
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (4) step(1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 8'h0A, 1'b1, 1'b0);
    step(1'b0, 8'h0A, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // 3: free 0, redispatch reuses 0 as youngest; 2 beats 0
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (4) step(1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 8'h01, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0);
    step(1'b0, 8'h05, 1'b1, 1'b0);
    step(1'b0, 8'h05, 1'b1, 1'b0);

    // 4: ALU stalled, then oldest goes
    step(1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);

    // 5: full queue, issue + dispatch same cycle -> no create, then refill freed slot
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (8) step(1'b1, '0, 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // 6: flush with dispatch and ready entries, then async reset mid-cycle
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step(1'b1, '0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_clk = 1'b0;
    idle_inputs();
    q.delete();
    #1 check_reset_state("async_rst");
    @(negedge clk);
    rst_clk = 1'b1;
    repeat (3) step(1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);

    // Randomized traffic
    repeat (500) begin
      step(($urandom % 4) != 0, D'($urandom), ($urandom % 4) != 0, ($urandom % 50) == 0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
